// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the core data port and the loader port.
// Uses round-robin arbitration, a loader lock with a starvation guard, and one-cycle read return.
module mem_port_arbiter #(
  parameter int unsigned MAX_LOCK = 8,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [3:0]        cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  input  logic              ldr_req,
  input  logic [3:0]        ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [31:0]       ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [31:0]       ldr_rdata,
  input  logic              ldr_lock,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       conflict_cnt
);

  typedef enum logic {OWN_CPU = 1'b0, OWN_LDR = 1'b1} owner_e;

  localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

  owner_e      last_q, last_d;
  logic [7:0]  lock_cnt_q, lock_cnt_d;
  logic [1:0]  rv_owner_q, rv_owner_d;   // {cpu, ldr}
  logic [31:0] conflict_q, conflict_d;
  logic        cpu_win, ldr_win;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q     <= OWN_LDR;
      lock_cnt_q <= '0;
      rv_owner_q <= '0;
      conflict_q <= '0;
    end else begin
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      rv_owner_q <= rv_owner_d;
      conflict_q <= conflict_d;
    end
  end

  always_comb begin
    cpu_win = 1'b0;
    ldr_win = 1'b0;
    if (!reset) begin
      if (cpu_req && ldr_req) begin
        if (ldr_lock) begin
          // Guard: once the loader has taken MAX_LOCK grants in a row, the core gets one.
          if (lock_cnt_q < MAX_LOCK_C) ldr_win = 1'b1;
          else                         cpu_win = 1'b1;
        end else if (last_q == OWN_LDR) begin
          cpu_win = 1'b1;
        end else begin
          ldr_win = 1'b1;
        end
      end else begin
        cpu_win = cpu_req;
        ldr_win = ldr_req;
      end
    end
  end

  always_comb begin
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    conflict_d = conflict_q;
    rv_owner_d = {cpu_win && (cpu_we == 4'b0000), ldr_win && (ldr_we == 4'b0000)};
    if (cpu_win)      last_d = OWN_CPU;
    else if (ldr_win) last_d = OWN_LDR;
    if (cpu_win || !ldr_lock)          lock_cnt_d = '0;
    else if (ldr_win && cpu_req)       lock_cnt_d = lock_cnt_q + 8'd1;
    if (cpu_req && ldr_req && (conflict_q != 32'hFFFF_FFFF)) conflict_d = conflict_q + 32'd1;
  end

  assign cpu_gnt      = cpu_win;
  assign ldr_gnt      = ldr_win;
  assign mem_en       = cpu_win | ldr_win;
  assign mem_we       = ldr_win ? ldr_we : (cpu_win ? cpu_we : 4'b0000);
  assign mem_addr     = ldr_win ? ldr_addr : cpu_addr;
  assign mem_wdata    = ldr_win ? ldr_wdata : cpu_wdata;
  assign cpu_rvalid   = rv_owner_q[1] & ~reset;
  assign ldr_rvalid   = rv_owner_q[0] & ~reset;
  assign cpu_rdata    = cpu_rvalid ? mem_rdata : 32'h0;
  assign ldr_rdata    = ldr_rvalid ? mem_rdata : 32'h0;
  assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, corner sequences, randomized model comparison.
module tb_mem_port_arbiter;
  localparam int MAXL = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, ldr_req, ldr_lock;
  logic [3:0]  cpu_we, ldr_we;
  logic [31:0] cpu_addr, ldr_addr, cpu_wdata, ldr_wdata, mem_rdata;
  logic        cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, mem_en;
  logic [31:0] cpu_rdata, ldr_rdata, mem_addr, mem_wdata, conflict_cnt;
  logic [3:0]  mem_we;

  int n_chk  = 0;
  int n_pass = 0;

  mem_port_arbiter #(.MAX_LOCK(MAXL), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
    .ldr_lock(ldr_lock),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic creq, input logic [3:0] cwe, input logic lreq,
                       input logic [3:0] lwe, input logic [31:0] lwd, input logic lk,
                       input logic [31:0] rd);
    cpu_req = creq; cpu_we = cwe; ldr_req = lreq; ldr_we = lwe;
    ldr_wdata = lwd; ldr_lock = lk; mem_rdata = rd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 4'hF, 1'b1, 4'hF, 32'h0, 1'b0, 32'h0);
    #1;
    chk("rst_cpu_gnt", {31'b0, cpu_gnt}, 32'd0);
    chk("rst_ldr_gnt", {31'b0, ldr_gnt}, 32'd0);
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_mem_we", {28'b0, mem_we}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0);
  endtask

  typedef struct {
    logic creq; logic [3:0] cwe; logic lreq; logic [3:0] lwe; logic [31:0] lwd;
    logic [31:0] rdata;
    logic ecg; logic elg; logic [3:0] emwe; logic [31:0] emaddr; logic [31:0] emwd;
    logic ecrv; logic elrv;
  } vec_t;

  vec_t tbl[9];

  // model state for random phase
  bit     m_last_cpu, m_pc, m_pl, ew_c, ew_l, rst_r;
  int     m_run;
  longint m_cnt;

  initial begin
    reset = 1'b0; cpu_addr = 32'h40; cpu_wdata = 32'h1111_1111; ldr_addr = 32'h80;
    drive(1'b0, 4'h0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0);

    tbl[0] = '{1'b1, 4'h0, 1'b0, 4'h0, 32'h0,      32'h0,         1'b1, 1'b0, 4'h0, 32'h40, 32'h1111_1111, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 4'h0, 1'b0, 4'h0, 32'h0,      32'hDEAD_BEEF, 1'b0, 1'b0, 4'h0, 32'h40, 32'h1111_1111, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 4'h0, 1'b1, 4'h2, 32'hAB00,   32'h0,         1'b0, 1'b1, 4'h2, 32'h80, 32'h0000_AB00, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 4'h0, 1'b0, 4'h0, 32'h0,      32'h1234_5678, 1'b0, 1'b0, 4'h0, 32'h40, 32'h1111_1111, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 4'h0, 1'b1, 4'h0, 32'h0,      32'h0,         1'b0, 1'b1, 4'h0, 32'h80, 32'h0,         1'b0, 1'b0};
    tbl[5] = '{1'b1, 4'h0, 1'b1, 4'h0, 32'h0,      32'hCAFE_F00D, 1'b1, 1'b0, 4'h0, 32'h40, 32'h1111_1111, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 4'hF, 1'b1, 4'h0, 32'h0,      32'h55AA_55AA, 1'b0, 1'b1, 4'h0, 32'h80, 32'h0,         1'b1, 1'b0};
    tbl[7] = '{1'b1, 4'hF, 1'b1, 4'h0, 32'h0,      32'h0BAD_CAFE, 1'b1, 1'b0, 4'hF, 32'h40, 32'h1111_1111, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 4'h0, 1'b0, 4'h0, 32'h0,      32'h7777_7777, 1'b0, 1'b0, 4'h0, 32'h40, 32'h1111_1111, 1'b0, 1'b0};

    do_reset();
    #1;
    chk("post_rst_conflict", conflict_cnt, 32'd0);
    chk("post_rst_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd0);
    chk("post_rst_ldr_rvalid", {31'b0, ldr_rvalid}, 32'd0);
    chk("post_rst_mem_addr", mem_addr, 32'h40);

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(tbl[i].creq, tbl[i].cwe, tbl[i].lreq, tbl[i].lwe, tbl[i].lwd, 1'b0, tbl[i].rdata);
      #1;
      chk($sformatf("v%0d_cpu_gnt", i), {31'b0, cpu_gnt}, {31'b0, tbl[i].ecg});
      chk($sformatf("v%0d_ldr_gnt", i), {31'b0, ldr_gnt}, {31'b0, tbl[i].elg});
      chk($sformatf("v%0d_mem_en", i), {31'b0, mem_en}, {31'b0, tbl[i].ecg | tbl[i].elg});
      chk($sformatf("v%0d_mem_we", i), {28'b0, mem_we}, {28'b0, tbl[i].emwe});
      chk($sformatf("v%0d_mem_addr", i), mem_addr, tbl[i].emaddr);
      chk($sformatf("v%0d_mem_wdata", i), mem_wdata, tbl[i].emwd);
      chk($sformatf("v%0d_cpu_rvalid", i), {31'b0, cpu_rvalid}, {31'b0, tbl[i].ecrv});
      chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata, tbl[i].ecrv ? tbl[i].rdata : 32'h0);
      chk($sformatf("v%0d_ldr_rvalid", i), {31'b0, ldr_rvalid}, {31'b0, tbl[i].elrv});
      chk($sformatf("v%0d_ldr_rdata", i), ldr_rdata, tbl[i].elrv ? tbl[i].rdata : 32'h0);
    end
    chk("tbl_conflict_cnt", conflict_cnt, 32'd3);

    // Round-robin from reset: CPU first, then alternating
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(1'b1, 4'h0, 1'b1, 4'h0, 32'h0, 1'b0, 32'h0);
      #1;
      chk($sformatf("rr%0d_cpu_gnt", i), {31'b0, cpu_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr%0d_ldr_gnt", i), {31'b0, ldr_gnt}, (i % 2 == 1) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    drive(1'b0, 4'h0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("rr_conflict_cnt", conflict_cnt, 32'd6);

    // Lock with starvation guard: core wins at slots 8 and 17
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(1'b1, 4'h0, 1'b1, 4'h0, 32'h0, 1'b1, 32'h0);
      #1;
      chk($sformatf("lk%0d_cpu_gnt", i), {31'b0, cpu_gnt}, (i == 8 || i == 17) ? 32'd1 : 32'd0);
      chk($sformatf("lk%0d_ldr_gnt", i), {31'b0, ldr_gnt}, (i == 8 || i == 17) ? 32'd0 : 32'd1);
    end

    // Reset mid-read: last becomes CPU, read granted, then reset
    @(negedge clk);
    drive(1'b1, 4'h0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("rmr_cpu_gnt", {31'b0, cpu_gnt}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 4'hF, 1'b1, 4'h3, 32'h0, 1'b0, 32'hFEED_0001);
    #1;
    chk("rmr_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd0);
    chk("rmr_cpu_rdata", cpu_rdata, 32'd0);
    chk("rmr_gnt_any", {30'b0, cpu_gnt, ldr_gnt}, 32'd0);
    chk("rmr_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rmr_mem_we", {28'b0, mem_we}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 4'h0, 1'b1, 4'h0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("rmr_conflict_zero", conflict_cnt, 32'd0);
    chk("rmr_first_cpu", {31'b0, cpu_gnt}, 32'd1);
    chk("rmr_no_rvalid", {30'b0, cpu_rvalid, ldr_rvalid}, 32'd0);

    // Randomized run against the reference model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst_r = (i == 0) || ($urandom_range(0, 63) == 0);
      reset = rst_r;
      cpu_req   = ($urandom_range(0, 3) != 0);
      ldr_req   = ($urandom_range(0, 3) != 0);
      ldr_lock  = ($urandom_range(0, 7) != 0);
      cpu_we    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      ldr_we    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      cpu_addr  = $urandom; ldr_addr  = $urandom;
      cpu_wdata = $urandom; ldr_wdata = $urandom; mem_rdata = $urandom;
      #1;
      ew_c = 1'b0; ew_l = 1'b0;
      if (!rst_r) begin
        if (cpu_req && ldr_req) begin
          if (ldr_lock) begin
            if (m_run >= MAXL) ew_c = 1'b1; else ew_l = 1'b1;
          end else if (m_last_cpu) ew_l = 1'b1;
          else ew_c = 1'b1;
        end else begin
          ew_c = cpu_req; ew_l = ldr_req;
        end
      end
      if (i > 0) begin
        chk("rnd_cpu_gnt", {31'b0, cpu_gnt}, {31'b0, ew_c});
        chk("rnd_ldr_gnt", {31'b0, ldr_gnt}, {31'b0, ew_l});
        chk("rnd_mem_en", {31'b0, mem_en}, {31'b0, ew_c | ew_l});
        chk("rnd_mem_we", {28'b0, mem_we}, ew_l ? {28'b0, ldr_we} : (ew_c ? {28'b0, cpu_we} : 32'd0));
        chk("rnd_mem_addr", mem_addr, ew_l ? ldr_addr : cpu_addr);
        chk("rnd_mem_wdata", mem_wdata, ew_l ? ldr_wdata : cpu_wdata);
        chk("rnd_cpu_rvalid", {31'b0, cpu_rvalid}, {31'b0, m_pc & ~rst_r});
        chk("rnd_cpu_rdata", cpu_rdata, (m_pc && !rst_r) ? mem_rdata : 32'h0);
        chk("rnd_ldr_rvalid", {31'b0, ldr_rvalid}, {31'b0, m_pl & ~rst_r});
        chk("rnd_ldr_rdata", ldr_rdata, (m_pl && !rst_r) ? mem_rdata : 32'h0);
        chk("rnd_conflict", conflict_cnt, 32'(m_cnt));
      end
      if (rst_r) begin
        m_last_cpu = 1'b0; m_run = 0; m_pc = 1'b0; m_pl = 1'b0; m_cnt = 0;
      end else begin
        if (ew_c) m_last_cpu = 1'b1;
        else if (ew_l) m_last_cpu = 1'b0;
        if (ew_c || !ldr_lock) m_run = 0;
        else if (ew_l && cpu_req) m_run = m_run + 1;
        m_pc = ew_c && (cpu_we == 4'h0);
        m_pl = ew_l && (ldr_we == 4'h0);
        if (cpu_req && ldr_req && m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end
    end

    // Counter saturation
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0);
    force dut.conflict_q = 32'hFFFF_FFFE;
    #1;
    release dut.conflict_q;
    #1;
    chk("sat_preload", conflict_cnt, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 4'h0, 1'b1, 4'h0, 32'h0, 1'b0, 32'h0);
      #1;
      if (i > 0) chk($sformatf("sat%0d", i), conflict_cnt, 32'hFFFF_FFFF);
    end
    @(negedge clk);
    drive(1'b0, 4'h0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("sat_hold", conflict_cnt, 32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single-port program/data memory between the hf-riscv core data port and the bench loader/debug port. Accesses are single-cycle issue with a fixed one-cycle read latency. Conflicts are resolved round-robin, and a loader lock mode allows back-to-back image loading. A starvation guard bounds the core's wait under lock. A saturating contention counter is exported for the bench coverage callbacks.

## Interface
- `MAX_LOCK`, 8: maximum consecutive loader grants under `ldr_lock` while `cpu_req` is pending; range 1..255.
- `ADDR_W`, 32: address width in bits. Data width is fixed at 32 bits.

Ports:
- `clk` in 1: clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `cpu_req` in 1: core access request; held until `cpu_gnt`.
- `cpu_we` in 4: byte write enables; `0000` denotes a read.
- `cpu_addr` in `ADDR_W`: core access address.
- `cpu_wdata` in 32: core write data.
- `cpu_gnt` out 1: core access issued this cycle.
- `cpu_rvalid` out 1: core read data valid.
- `cpu_rdata` out 32: core read data.
- `ldr_req`, `ldr_we`, `ldr_addr`, `ldr_wdata`, `ldr_gnt`, `ldr_rvalid`, `ldr_rdata`: loader port; same directions, widths and meanings as the `cpu_*` ports.
- `ldr_lock` in 1: loader priority request; only meaningful together with `ldr_req`.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 4: memory byte write enables.
- `mem_addr` out `ADDR_W`: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data; valid the cycle after `mem_en` with `mem_we==0`.
- `conflict_cnt` out 32: count of cycles with both requests asserted; saturates at `0xFFFFFFFF`.

## Operation
- **State:**
  - `last`: last winner, CPU or LDR; reset value LDR.
  - `lock_cnt`: 8-bit counter; reset value 0.
  - `rv_owner`: 2-bit pending-read flags, {cpu, ldr}; reset value 00.
  - `conflict_cnt`: reset value 0.
- **Winner selection** is combinational and evaluated each cycle:
  - Neither requesting: no grant.
  - Exactly one requesting: that requester wins.
  - Both requesting, `ldr_lock=1` and `lock_cnt<MAX_LOCK`: LDR wins.
  - Both requesting, `ldr_lock=1` and `lock_cnt==MAX_LOCK`: CPU wins (starvation guard).
  - Both requesting, `ldr_lock=0`: the requester that is not `last` wins (round-robin).
- **Grant:** `x_gnt=1` for the winner only. `mem_en=1`, and `mem_we`, `mem_addr` and `mem_wdata` are muxed from the winner. When there is no winner, `mem_en=0` and `mem_we=0`; address and data are don't-care but driven from the CPU bus.
- **`last`** is updated to the winner on every grant.
- **`lock_cnt` update:**
  - +1 on an LDR grant while `cpu_req=1` and `ldr_lock=1`.
  - Cleared on any CPU grant, and whenever `ldr_lock=0`.
  - Holds otherwise.
- **Read return:** `rv_owner` records the winner of a granted read (`we==0`). Next cycle, `x_rvalid = rv_owner[x]` and `x_rdata = mem_rdata` when `x_rvalid=1`, else 0. Writes produce no `rvalid`.
- **`conflict_cnt`:** +1 on each non-reset cycle with `cpu_req & ldr_req`; saturates.

## Timing
- **Issue latency:** grant in the same cycle as the request if it wins; 0 wait cycles when uncontended.
- **Read latency:** `rvalid` exactly 1 cycle after the granted read. A new access may be granted in that same cycle, giving full throughput.
- **Requester obligations:** requesters keep `req`, `we`, `addr` and `wdata` stable until `gnt`. Dropping `req` before `gnt` is legal and abandons the access.
- **Worst-case CPU wait:**
  - Unlocked: 1 cycle.
  - Locked: `MAX_LOCK` cycles.
- **During a reset cycle:**
  - All grants, `mem_en` and `mem_we` are forced to 0.
  - On the following edge all state takes its reset value. Any read granted in the cycle before reset gets no `rvalid`.
- **All outputs after reset:** 0, except `mem_addr`/`mem_wdata` follow the CPU bus.
- **Changes to `ldr_lock` mid-burst** take effect in the same cycle.

## Test plan
- **Uncontended CPU read:** `cpu_req` with `addr=0x40`, memory returns `0xDEADBEEF` → `cpu_gnt` in cycle 0, `mem_en`/`mem_addr=0x40` in cycle 0, `cpu_rvalid=1` with `cpu_rdata=0xDEADBEEF` in cycle 1, `ldr_rvalid=0`.
- **Contention round-robin:** both `req` held high for 6 cycles, unlocked, from reset → grants alternate CPU, LDR, CPU, LDR, CPU, LDR; `conflict_cnt=6`.
- **Lock with starvation guard:** `MAX_LOCK=8`, `ldr_lock=1`, both requesting for 20 cycles → 8 LDR grants, 1 CPU, 8 LDR, 1 CPU, 2 LDR; `lock_cnt` returns to 0 after each CPU grant.
- **Byte write:** LDR write with `we=0010` and `wdata=0x0000AB00` → `mem_we=0010` and `mem_wdata` passed through; no `rvalid` on either port the next cycle.
- **Reset mid-read:** CPU read granted in cycle N, `reset=1` in cycle N+1 → `cpu_rvalid=0` in N+1; all grants 0 during reset; `conflict_cnt=0` and `last=LDR` afterwards, so the first contention goes to CPU.
- **Counter saturation:** force `conflict_cnt` to `0xFFFFFFFE`, then 3 contended cycles → counter holds at `0xFFFFFFFF`.
